// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the pwm_capture channel.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } cap_state_t;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILTER_LEN  = 4;

  // All-ones value of a w-bit counter; the counter saturates here.
  function automatic logic [31:0] cnt_sat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_input_conditioner.sv
// Synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN) and edge detect
// for the asynchronous PWM input.
module pwm_input_conditioner
  import pwm_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sy;
  logic                   lvl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign sy = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FCNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic [FCNT_W-1:0] filt_cnt;
  logic              lvl_f;

  // Counts consecutive samples disagreeing with the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_f    <= 1'b0;
      filt_cnt <= '0;
    end else if (sy == lvl_f) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
      lvl_f    <= sy;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FCNT_W'(1);
    end
  end

  assign lvl = lvl_f;
`else
  assign lvl = sy;

  // FILTER_LEN stays in the parameter list so both builds share one interface.
  if (FILTER_LEN == 0) begin : g_filter_len_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl;
    end
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period/high-time capture with valid/ready result handshake and
// stuck-level timeout. Optional input glitch filter: PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             overrun,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(CNT_W));

  logic             lvl, rise, fall;
  cap_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, high_q;
  logic             do_latch, do_publish, do_timeout;

  pwm_input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_cond (
    .clk   (clk),
    .reset (reset),
    .pwm_in(pwm_in),
    .lvl   (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Timeout takes priority over an edge seen in the same cycle.
  always_comb begin
    state_next = state;
    do_latch   = 1'b0;
    do_publish = 1'b0;
    do_timeout = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_ARM;
        ST_ARM:  if (rise) state_next = ST_HIGH;
        ST_HIGH: begin
          if (cnt == CNT_SAT) begin
            do_timeout = 1'b1;
            state_next = ST_ARM;
          end else if (fall) begin
            do_latch   = 1'b1;
            state_next = ST_LOW;
          end
        end
        ST_LOW: begin
          if (cnt == CNT_SAT) begin
            do_timeout = 1'b1;
            state_next = ST_ARM;
          end else if (rise) begin
            do_publish = 1'b1;
            state_next = ST_HIGH;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_SAT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      high_q <= '0;
    end else if (do_latch) begin
      high_q <= cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meas_valid  <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      overrun     <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      if (do_publish) begin
        if (!meas_valid || meas_ready) begin
          meas_valid <= 1'b1;
          period_out <= cnt;
          high_out   <= high_q;
          overrun    <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      if (do_timeout) begin
        stuck       <= 1'b1;
        stuck_level <= lvl;
      end else if (rise) begin
        stuck <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: per complete cycle, the period and high time in `clk` cycles. It is the receive-side counterpart of the on-chip PWM generator and sits on the peripheral bus side as a capture channel. Results are delivered to the CPU register wrapper through a valid/ready handshake, and a stuck-level timeout flags inputs stuck at 0 % or 100 % duty.

## Interface
- `CNT_W`, 16: width of the period and high-time counters and results.
- `SYNC_STAGES`, 2: number of synchronizer flops on `pwm_in`; minimum 2.
- `FILTER_LEN`, 4: number of consecutive equal samples needed to accept a level change. Used only with the filter macro.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  capture enable; low forces IDLE.
- `pwm_in`  in  1  asynchronous PWM input.
- `meas_ready`  in  1  consumer accepts the result.
- `meas_valid`  out  1  a result is held on `period_out` and `high_out`.
- `period_out`  out  CNT_W  clk cycles from one rising edge to the next.
- `high_out`  out  CNT_W  clk cycles from a rising edge to the following falling edge.
- `overrun`  out  1  sticky: a completed result was dropped.
- `stuck`  out  1  timeout occurred; cleared on the next rising edge.
- `stuck_level`  out  1  level of `pwm_in` at the timeout.

## Operation
- **Input conditioning:** `pwm_in` passes through `SYNC_STAGES` flops, giving `lvl`. The previous sample `lvl_q` gives `rise = lvl & ~lvl_q` and `fall = ~lvl & lvl_q`.
- **Counter `cnt` (CNT_W bits):**
  - On `rise`, load 1.
  - Otherwise increment, saturating at 2^CNT_W−1.
  - At any cycle, `cnt` equals the number of cycles since the last `rise`.
- **States:** IDLE, ARM, HIGH, LOW.
  - IDLE: entered when `enable` = 0 from any state; `cnt` cleared. Goes to ARM when `enable` = 1.
  - ARM: waits for the first `rise`, then goes to HIGH. This first partial cycle is never published.
  - HIGH: on `fall`, latch `high_q <= cnt` and go to LOW.
  - LOW: on `rise`, publish `period = cnt` and `high = high_q`, then go to HIGH.
- **Timeout:** if `cnt` reaches saturation in HIGH or LOW:
  - set `stuck` and capture `stuck_level = lvl`;
  - go to ARM;
  - publish nothing.
- **Publish rule:**
  - If `meas_valid` = 0, or `meas_valid & meas_ready` in the same cycle: load the outputs and keep `meas_valid` = 1.
  - Otherwise: drop the new result, set `overrun`, and leave the outputs unchanged.
- **Handshake:** `meas_valid` holds until sampled with `meas_ready` = 1. Outputs are stable while valid. `overrun` clears on the accepting handshake.
- **Disabling:** deasserting `enable` does not discard a pending valid result.
- **Impossible events:** `rise` in HIGH and `fall` in LOW cannot occur, because edges alternate.

## Timing
- **Reset values:** `meas_valid`, `period_out`, `high_out`, `overrun`, `stuck`, `stuck_level` all 0; state IDLE; synchronizer flops 0.
- **Pin to edge detection:** `SYNC_STAGES`+1 clk. The delay is constant, so measured values are unaffected.
- **Publish latency:** `meas_valid` rises 1 cycle after the `rise` that completes a period.
- **Input requirement:** minimum measurable high or low phase is 1 clk (input must be synchronous-clean; see Configuration for noisy inputs).
- **Maximum measurable period:** 2^CNT_W−2 cycles. Reaching 2^CNT_W−1 is a timeout.
- **Reset mid-operation:** everything returns to its reset value on the next edge; no partial result is published.

## Configuration
- Macro: `PWM_CAPTURE_FILTER_EN`.
- **Defined:**
  - `lvl` changes only after `FILTER_LEN` consecutive equal synchronized samples.
  - Pulses shorter than `FILTER_LEN` clk are rejected.
  - Adds `FILTER_LEN` cycles of constant latency.
- **Undefined:** `lvl` is the synchronizer output directly, and `FILTER_LEN` is unused.

## Structure
- **Package `pwm_capture_pkg`:**
  - state encoding for IDLE/ARM/HIGH/LOW;
  - default `CNT_W`, `SYNC_STAGES`, `FILTER_LEN`;
  - saturation constant.
- **Sub-module `pwm_input_conditioner`:** synchronizer, optional filter, and `rise`/`fall` detection. The top level holds the FSM, counter, and handshake.

## Test plan
- **Nominal:** drive from the PWM generator with period=99, duty_cycle=25, `meas_ready`=1. Expect `period_out`=100 and `high_out`=25 on each result, and the first partial cycle not reported.
- **Backpressure:** `meas_ready`=0 across two completed periods. Expect the first result held, `overrun`=1 after the second completion, and `overrun` clearing on the handshake when `meas_ready`=1.
- **Simultaneous accept and completion:** handshake occurs in the same cycle as the next completion. Expect the new values loaded, `meas_valid` staying 1, and `overrun`=0.
- **Stuck input:** hold `pwm_in`=1 with CNT_W=8 after one rise. Expect `stuck`=1 and `stuck_level`=1 after 255 cycles with no result; a later valid waveform clears `stuck` and yields results again.
- **Enable and reset mid-measurement:** drop `enable` mid-HIGH and expect IDLE with no result. Assert `reset` mid-LOW and expect all outputs 0.
- **With `PWM_CAPTURE_FILTER_EN` and FILTER_LEN=4:** a 2-cycle glitch inside the low phase is ignored, and the reported values match the unglitched waveform.
